// File: rtl/data_mem_ctrl_if.sv
// Bus bundle between the execute stage, the data memory and data_mem_ctrl.
// The slave modport is the controller's view; the master modport is the
// view of the surrounding core and memory.
interface data_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32
) ();
    // Core request side
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        store_op;
    logic [2:0]        read_op;
    logic              stall;
    logic              done;
    logic              misalign;

    // Memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    // Load result towards the alignment/sign-extension mux
    logic [31:0]       rd_data;
    logic [1:0]        rd_addr;
    logic [2:0]        rd_op;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, store_op, read_op,
        input  mem_ready, mem_rvalid, mem_rdata,
        output stall, done, misalign,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output rd_data, rd_addr, rd_op
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, store_op, read_op,
        output mem_ready, mem_rvalid, mem_rdata,
        input  stall, done, misalign,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  rd_data, rd_addr, rd_op
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory access controller. Takes one load/store from the
// execute stage, issues it to a valid/ready memory and stalls the core until
// the access completes. store_op gives the access size for loads as well as
// stores, so it also drives misalignment detection for loads.
module data_mem_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input logic            clk,
    input logic            rst_n,
    data_mem_ctrl_if.slave bus_io
);

    typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [1:0]        off_q;
    logic [2:0]        op_q;
    logic              mis_q, mis_d;
    logic [31:0]       rd_data_q;
    logic [1:0]        rd_addr_q;
    logic [2:0]        rd_op_q;

    logic              latch_req;
    logic              capture_rd;
    logic              req_mis;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata_rep;

    // Decode the incoming request: lane enables, replicated data, alignment.
    always_comb begin
        req_mis       = 1'b0;
        req_be        = 4'b1111;
        req_wdata_rep = bus_io.req_wdata;
        case (bus_io.store_op)
            2'b00: begin
                req_be        = 4'b0001 << bus_io.req_addr[1:0];
                req_wdata_rep = {4{bus_io.req_wdata[7:0]}};
            end
            2'b01: begin
                req_mis       = bus_io.req_addr[0];
                req_be        = bus_io.req_addr[1] ? 4'b1100 : 4'b0011;
                req_wdata_rep = {2{bus_io.req_wdata[15:0]}};
            end
            default: begin
                // Word and reserved encodings both behave as a word access.
                req_mis = |bus_io.req_addr[1:0];
            end
        endcase
        if (!bus_io.req_write) begin
            req_be = 4'b1111;
        end
    end

    // Next-state logic and single-cycle control strobes.
    always_comb begin
        state_d    = state_q;
        mis_d      = 1'b0;
        latch_req  = 1'b0;
        capture_rd = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus_io.req_valid) begin
                    if (req_mis) begin
                        // No memory traffic: report the fault and finish.
                        mis_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        latch_req = 1'b1;
                        state_d   = StReq;
                    end
                end
            end
            StReq: begin
                if (bus_io.mem_ready) begin
                    state_d = we_q ? StDone : StResp;
                end
            end
            StResp: begin
                if (bus_io.mem_rvalid) begin
                    capture_rd = 1'b1;
                    state_d    = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register; a reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mis_q   <= mis_d;
        end
    end

    // Request registers hold the mem_* outputs stable across the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            off_q   <= '0;
            op_q    <= '0;
        end else if (latch_req) begin
            addr_q  <= {bus_io.req_addr[ADDR_W-1:2], 2'b00};
            we_q    <= bus_io.req_write;
            wdata_q <= req_wdata_rep;
            be_q    <= req_be;
            off_q   <= bus_io.req_addr[1:0];
            op_q    <= bus_io.read_op;
        end
    end

    // Load result registers only move when a load actually returns data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
            rd_addr_q <= '0;
            rd_op_q   <= '0;
        end else if (capture_rd) begin
            rd_data_q <= bus_io.mem_rdata;
            rd_addr_q <= off_q;
            rd_op_q   <= op_q;
        end
    end

    // Output drive.
    always_comb begin
        bus_io.mem_req   = (state_q == StReq);
        bus_io.mem_we    = we_q;
        bus_io.mem_addr  = addr_q;
        bus_io.mem_wdata = wdata_q;
        bus_io.mem_be    = be_q;
        bus_io.done      = (state_q == StDone);
        bus_io.misalign  = mis_q;
        bus_io.stall     = bus_io.req_valid & (state_q != StDone);
        bus_io.rd_data   = rd_data_q;
        bus_io.rd_addr   = rd_addr_q;
        bus_io.rd_op     = rd_op_q;
    end

endmodule
